cmp_pipe: RTL

//   Parametrised, pipelined branch/set-less-than comparator for the RV32I execute path.

---
 rtl/rv32i_types_pkg.sv | 18 +
 rtl/cmp_pipe_eval.sv | 45 ++++
 rtl/cmp_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv32i_types_pkg.sv
// RV32I shared type definitions: comparison kind and branch funct3 encodings.
package rv32i_types;

  typedef enum logic {
    CMP_BR  = 1'b0,
    CMP_SET = 1'b1
  } cmp_kind_t;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

endpackage

// File: rtl/cmp_pipe_eval.sv
// Combinational branch / set-less-than evaluator on WIDTH-bit operands.
// funct3 codes 010/011 under CMP_BR flag illegal and never report taken.
module cmp_eval
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  cmp_kind_t        i_kind,
  input  logic [2:0]       i_funct3,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_br_en,
  output logic             o_set,
  output logic             o_illegal
);

  logic w_eq;
  logic w_lts;
  logic w_ltu;

  assign w_eq  = (i_a == i_b);
  assign w_lts = ($signed(i_a) < $signed(i_b));
  assign w_ltu = (i_a < i_b);

  // Decode kind/funct3 into taken, set result and illegal flag.
  always_comb begin
    o_br_en   = 1'b0;
    o_set     = 1'b0;
    o_illegal = 1'b0;
    if (i_kind == CMP_SET) begin
      o_set = i_funct3[0] ? w_ltu : w_lts;
    end else begin
      case (branch_funct3_t'(i_funct3))
        BR_BEQ:  o_br_en = w_eq;
        BR_BNE:  o_br_en = !w_eq;
        BR_BLT:  o_br_en = w_lts;
        BR_BGE:  o_br_en = !w_lts;
        BR_BLTU: o_br_en = w_ltu;
        BR_BGEU: o_br_en = !w_ltu;
        default: o_illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/cmp_pipe.sv
// Pipelined RV32I branch / SLT(U) comparator with tag, valid/ready and flush.
// Optional perf counters are built only when CMP_PIPE_PERF_EN is defined;
// otherwise perf_taken/perf_ntaken are tied to zero.
module cmp_pipe
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_kind,
  input  logic [2:0]       in_funct3,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_br_en,
  output logic [WIDTH-1:0] out_result,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag,
  output logic [31:0]      perf_taken,
  output logic [31:0]      perf_ntaken
);

  typedef struct packed {
    cmp_kind_t        kind;
    logic             br_en;
    logic             set;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } cmp_pipe_entry_t;

  localparam int unsigned LAST = STAGES - 1;

  logic            w_br_en;
  logic            w_set;
  logic            w_illegal;
  logic            w_accept;
  cmp_pipe_entry_t w_new;
  logic [STAGES-1:0] w_v;
  logic [STAGES-1:0] w_go;
  cmp_pipe_entry_t   w_e [STAGES];

  cmp_eval #(
    .WIDTH(WIDTH)
  ) u_eval (
    .i_kind   (cmp_kind_t'(in_kind)),
    .i_funct3 (in_funct3),
    .i_a      (in_a),
    .i_b      (in_b),
    .o_br_en  (w_br_en),
    .o_set    (w_set),
    .o_illegal(w_illegal)
  );

  assign w_new = '{kind: cmp_kind_t'(in_kind), br_en: w_br_en, set: w_set,
                   illegal: w_illegal, tag: in_tag};

  // A stage may load when it is empty or its successor moves on; bubbles collapse.
  always_comb begin
    w_go       = '0;
    w_go[LAST] = !w_v[LAST] || out_ready;
    for (int unsigned i = 1; i < STAGES; i++) begin
      w_go[LAST-i] = !w_v[LAST-i] || w_go[LAST-i+1];
    end
  end

  assign in_ready = w_go[0] && !flush;
  assign w_accept = in_valid && in_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic            r_v;
    cmp_pipe_entry_t r_e;
    logic            w_src_v;
    cmp_pipe_entry_t w_src_e;

    if (k == 0) begin : g_head
      assign w_src_v = w_accept;
      assign w_src_e = w_new;
    end else begin : g_body
      assign w_src_v = w_v[k-1];
      assign w_src_e = w_e[k-1];
    end

    // Stage register: flush clears valid, otherwise load from predecessor when free.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_e <= '0;
      end else if (flush) begin
        r_v <= 1'b0;
      end else if (w_go[k]) begin
        r_v <= w_src_v;
        r_e <= w_src_e;
      end
    end

    assign w_v[k] = r_v;
    assign w_e[k] = r_e;
  end

  assign out_valid   = w_v[LAST];
  assign out_br_en   = w_v[LAST] && (w_e[LAST].kind == CMP_BR) && w_e[LAST].br_en;
  assign out_result  = WIDTH'(w_v[LAST] && w_e[LAST].set);
  assign out_illegal = w_v[LAST] && w_e[LAST].illegal;
  assign out_tag     = w_v[LAST] ? w_e[LAST].tag : '0;

`ifdef CMP_PIPE_PERF_EN
  logic [31:0] r_taken;
  logic [31:0] r_ntaken;
  logic        w_count;

  // Results shown in a flush cycle are squashed, so they are not counted.
  assign w_count = out_valid && out_ready && !flush &&
                   (w_e[LAST].kind == CMP_BR) && !w_e[LAST].illegal;

  // Saturating taken / not-taken counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_taken  <= '0;
      r_ntaken <= '0;
    end else if (w_count) begin
      if (w_e[LAST].br_en) begin
        if (r_taken != '1) r_taken <= r_taken + 32'd1;
      end else begin
        if (r_ntaken != '1) r_ntaken <= r_ntaken + 32'd1;
      end
    end
  end

  assign perf_taken  = r_taken;
  assign perf_ntaken = r_ntaken;
`else
  assign perf_taken  = '0;
  assign perf_ntaken = '0;
`endif

endmodule
